mem_arbiter: RTL and testbench

Two-port arbiter and burst sequencer in front of the unified `memory` block. It shares the single memory port between the instruction-fetch stage (port 0) and the load/store stage (port 1). Each granted request is expanded into a 1/4/8/16-word burst of word accesses, and read data is steered back to the owning requester. It sits between the pipeline front/back ends and `memory`, and it is the only module that drives memory's `address`/`data_in`/`access_size`/`rw`/`enable`.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/rr_arbiter2.sv | 19 +
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: access-size codes, rw encoding
// and the burst sequencer state type.
package mem_pkg;

  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [4:0] size_words(input logic [1:0] size);
    logic [4:0] words;
    case (size)
      SIZE_1:  words = 5'd1;
      SIZE_4:  words = 5'd4;
      SIZE_8:  words = 5'd8;
      default: words = 5'd16;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: on contention the port that did not win
// last time is chosen. Purely combinational one-hot result.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between fetch (port 0) and load/store (port 1),
// expanding each grant into a word burst and steering read data to its owner.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int address_width = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [address_width-1:0] p0_addr,
  input  logic [address_width-1:0] p1_addr,
  input  logic                     p0_rw,
  input  logic                     p1_rw,
  input  logic [1:0]               p0_size,
  input  logic [1:0]               p1_size,
  input  logic [data_width-1:0]    p0_wdata,
  input  logic [data_width-1:0]    p1_wdata,
  output logic [1:0]               gnt,
  output logic [1:0]               wready,
  output logic [1:0]               rvalid,
  output logic [data_width-1:0]    rdata,
  output logic [1:0]               done,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_data_in,
  output logic [1:0]               mem_access_size,
  output logic                     mem_rw,
  output logic                     mem_enable,
  input  logic                     mem_busy,
  input  logic [data_width-1:0]    mem_data_out
);

  localparam logic [address_width-1:0] ADDR_STEP  = address_width'(WORD_BYTES);
  localparam logic [address_width-1:0] ALIGN_MASK = ~address_width'(WORD_BYTES - 1);

  arb_state_e                 state_q, state_d;
  logic                       last_q, last_d;
  logic                       owner_q, owner_d;
  logic [address_width-1:0]   addr_q, addr_d;
  logic                       rw_q, rw_d;
  logic [1:0]                 size_q, size_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [1:0]                 gnt_q, gnt_d;
  logic [1:0]                 done_q, done_d;
  logic [1:0]                 rvalid_q, rvalid_d;
  logic [data_width-1:0]      rdata_q, rdata_d;

  logic [1:0]                 pickGnt;
  logic                       pickPort;
  logic [address_width-1:0]   selAddr;
  logic                       selRw;
  logic [1:0]                 selSize;
  logic [4:0]                 selWordsM1;
  logic [1:0]                 ownerMask;
  logic                       inBurst;
  logic                       writeBeat;

  rr_arbiter2 u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pickGnt)
  );

  assign pickPort   = pickGnt[1];
  assign selAddr    = pickPort ? p1_addr : p0_addr;
  assign selRw      = pickPort ? p1_rw   : p0_rw;
  assign selSize    = pickPort ? p1_size : p0_size;
  assign selWordsM1 = size_words(selSize) - 5'd1;
  assign ownerMask  = owner_q ? 2'b10 : 2'b01;

  // Burst sequencing: a beat only advances while memory is not busy, and the
  // read word captured on each advance is returned the following cycle.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pickGnt;
          last_d  = pickPort;
          owner_d = pickPort;
          addr_d  = selAddr & ALIGN_MASK;
          rw_d    = selRw;
          size_d  = selSize;
          cnt_d   = selWordsM1[3:0];
          state_d = BURST;
        end
      end
      BURST: begin
        if (!mem_busy) begin
          addr_d = addr_q + ADDR_STEP;
          cnt_d  = cnt_q - 4'd1;
          if (rw_q == RW_READ) begin
            rvalid_d = ownerMask;
            rdata_d  = mem_data_out;
          end
          if (cnt_q == 4'd0) begin
            done_d  = ownerMask;
            state_d = (rw_q == RW_READ) ? DRAIN : IDLE;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      cnt_q    <= 4'd0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory-side outputs are forced to zero outside BURST so reset and idle
  // leave the memory port quiet.
  assign inBurst         = (state_q == BURST);
  assign writeBeat       = inBurst && (rw_q == RW_WRITE);
  assign mem_enable      = inBurst;
  assign mem_address     = inBurst ? addr_q : '0;
  assign mem_rw          = inBurst && rw_q;
  assign mem_access_size = inBurst ? size_q : 2'b00;
  assign mem_data_in     = writeBeat ? (owner_q ? p1_wdata : p0_wdata) : '0;
  assign wready          = (writeBeat && !mem_busy) ? ownerMask : 2'b00;

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model (round-robin
// rule, word-address arithmetic, reference memory) predicts every cycle.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] p0Addr, p1Addr;
  logic        p0Rw, p1Rw;
  logic [1:0]  p0Size, p1Size;
  logic [31:0] p0Wdata, p1Wdata;
  logic [1:0]  gnt, wready, rvalid, done;
  logic [31:0] rdata;
  logic [31:0] memAddress, memDataIn, memDataOut;
  logic [1:0]  memAccessSize;
  logic        memRw, memEnable, memBusy;

  int assertCount;
  int failCount;

  logic [31:0] stubMem [logic [29:0]];
  logic [31:0] refMem  [logic [29:0]];

  logic [31:0] cfgAddr [2];
  logic        cfgRw   [2];
  logic [1:0]  cfgSize [2];
  logic [31:0] cfgData [2][16];

  int modelLast;
  int expWait;
  int busyMode;
  int stallAt;
  int stallLen;
  int abortAt;
  bit aborted;

  mem_arbiter #(.data_width(32), .address_width(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .p0_addr         (p0Addr),
    .p1_addr         (p1Addr),
    .p0_rw           (p0Rw),
    .p1_rw           (p1Rw),
    .p0_size         (p0Size),
    .p1_size         (p1Size),
    .p0_wdata        (p0Wdata),
    .p1_wdata        (p1Wdata),
    .gnt             (gnt),
    .wready          (wready),
    .rvalid          (rvalid),
    .rdata           (rdata),
    .done            (done),
    .mem_address     (memAddress),
    .mem_data_in     (memDataIn),
    .mem_access_size (memAccessSize),
    .mem_rw          (memRw),
    .mem_enable      (memEnable),
    .mem_busy        (memBusy),
    .mem_data_out    (memDataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] stubRead(input logic [29:0] w);
    if (stubMem.exists(w)) return stubMem[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a[31:2])) return refMem[a[31:2]];
    return 32'h0;
  endfunction

  function automatic int wordsOf(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [1:0] onehot(input int port);
    return (port == 1) ? 2'b10 : 2'b01;
  endfunction

  // Memory stub: the word at the presented address is readable by the arbiter
  // at the end of the same cycle.
  always @(negedge clock) memDataOut <= stubRead(memAddress[31:2]);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic preloadWord(input logic [31:0] addr, input logic [31:0] value);
    stubMem[addr[31:2]] = value;
    refMem[addr[31:2]]  = value;
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] addr,
                               input logic rw, input logic [1:0] size);
    cfgAddr[port] = addr;
    cfgRw[port]   = rw;
    cfgSize[port] = size;
    if (port == 0) begin
      p0Addr = addr; p0Rw = rw; p0Size = size; req[0] = 1'b1;
    end else begin
      p1Addr = addr; p1Rw = rw; p1Size = size; req[1] = 1'b1;
    end
  endtask

  task automatic scramblePort(input int port);
    if (port == 0) begin
      p0Addr = $urandom; p0Rw = 1'($urandom_range(0, 1)); p0Size = 2'($urandom_range(0, 3));
    end else begin
      p1Addr = $urandom; p1Rw = 1'($urandom_range(0, 1)); p1Size = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic driveWdata(input int port, input logic [31:0] value);
    if (port == 0) begin
      p0Wdata = value; p1Wdata = $urandom;
    end else begin
      p1Wdata = value; p0Wdata = $urandom;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".gnt"},        32'(gnt),           32'h0);
    checkOutput({tag, ".wready"},     32'(wready),        32'h0);
    checkOutput({tag, ".rvalid"},     32'(rvalid),        32'h0);
    checkOutput({tag, ".rdata"},      rdata,              32'h0);
    checkOutput({tag, ".done"},       32'(done),          32'h0);
    checkOutput({tag, ".memAddress"}, memAddress,         32'h0);
    checkOutput({tag, ".memDataIn"},  memDataIn,          32'h0);
    checkOutput({tag, ".accessSize"}, 32'(memAccessSize), 32'h0);
    checkOutput({tag, ".memRw"},      32'(memRw),         32'h0);
    checkOutput({tag, ".memEnable"},  32'(memEnable),     32'h0);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1; req = 2'b00; memBusy = 1'b0;
    #1;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;
    modelLast = 1;
    expWait = 1;
  endtask

  // Waits for the predicted grant, then walks the burst cycle by cycle
  // against the model's beat count, addresses, read data and done timing.
  task automatic serviceOne();
    int port, waited, n, c, mBeats;
    bit prevAdv, adv, expEn, expDone, expRv, rdFlag, finished;
    logic [31:0] base, beatAddr, prevAddr;
    aborted = 1'b0;
    port = (req == 2'b11) ? ((modelLast == 1) ? 0 : 1) : (req[1] ? 1 : 0);
    waited = 0;
    do begin
      @(negedge clock);
      memBusy = 1'b0;
      #1;
      waited++;
    end while (gnt == 2'b00 && waited < 20);
    checkOutput("gnt", 32'(gnt), 32'(onehot(port)));
    checkOutput("grantLatency", waited, expWait);
    if (gnt == 2'b00) return;
    modelLast = port;
    req[port] = 1'b0;
    scramblePort(port);

    n = wordsOf(cfgSize[port]);
    base = cfgAddr[port] & 32'hFFFF_FFFC;
    rdFlag = cfgRw[port];
    mBeats = 0; prevAdv = 1'b0; c = 0; finished = 1'b0;
    while (!finished) begin
      if (c > 0) @(negedge clock);
      if (c == abortAt) begin
        aborted = 1'b1;
        return;
      end
      case (busyMode)
        1:       memBusy = (c >= stallAt) && (c < stallAt + stallLen);
        2:       memBusy = (c < 60) && ($urandom_range(0, 3) == 0);
        default: memBusy = 1'b0;
      endcase
      driveWdata(port, (mBeats < n) ? cfgData[port][mBeats] : $urandom);
      #1;
      expEn    = (mBeats < n);
      expDone  = (mBeats == n);
      expRv    = prevAdv && rdFlag;
      beatAddr = base + 32'(mBeats * 4);
      prevAddr = base + 32'((mBeats - 1) * 4);
      checkOutput("memEnable", 32'(memEnable), 32'(expEn));
      if (c > 0) checkOutput("gntQuiet", 32'(gnt), 32'h0);
      checkOutput("done", 32'(done), expDone ? 32'(onehot(port)) : 32'h0);
      checkOutput("rvalid", 32'(rvalid), expRv ? 32'(onehot(port)) : 32'h0);
      if (expRv) checkOutput("rdata", rdata, refRead(prevAddr));
      if (expEn) begin
        checkOutput("memAddress", memAddress, beatAddr);
        checkOutput("memRw", 32'(memRw), 32'(rdFlag));
        checkOutput("accessSize", 32'(memAccessSize), 32'(cfgSize[port]));
        if (!rdFlag) begin
          checkOutput("wready", 32'(wready), memBusy ? 32'h0 : 32'(onehot(port)));
          if (!memBusy) checkOutput("memDataIn", memDataIn, cfgData[port][mBeats]);
        end else begin
          checkOutput("wreadyRead", 32'(wready), 32'h0);
        end
      end else begin
        checkOutput("wreadyIdle", 32'(wready), 32'h0);
      end
      if (memEnable && !memBusy && !memRw) stubMem[memAddress[31:2]] = memDataIn;
      adv = expEn && !memBusy;
      if (adv) begin
        if (!rdFlag) refMem[beatAddr[31:2]] = cfgData[port][mBeats];
        mBeats++;
      end
      prevAdv = adv;
      if (expDone) finished = 1'b1;
      c++;
      if (c > 150) begin
        checkOutput("burstBound", c, 150);
        finished = 1'b1;
      end
    end
    memBusy = 1'b0;
    expWait = rdFlag ? 2 : 1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] mask;
    int cnt;
    logic [31:0] a;
    assertCount = 0; failCount = 0;
    reset = 1'b0; req = 2'b00; memBusy = 1'b0;
    p0Addr = '0; p1Addr = '0; p0Rw = 1'b0; p1Rw = 1'b0;
    p0Size = 2'b00; p1Size = 2'b00; p0Wdata = '0; p1Wdata = '0;
    busyMode = 0; stallAt = 0; stallLen = 0; abortAt = -1;
    modelLast = 1; expWait = 1;
    for (int p = 0; p < 2; p++) begin
      cfgAddr[p] = '0; cfgRw[p] = 1'b1; cfgSize[p] = 2'b00;
      for (int k = 0; k < 16; k++) cfgData[p][k] = $urandom;
    end
    #2 reset = 1'b1;
    @(negedge clock);
    #1;
    checkAllZero("powerOn");
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single 4-word read on port 0");
    preloadWord(32'h8002_0000, 32'h11);
    preloadWord(32'h8002_0004, 32'h22);
    preloadWord(32'h8002_0008, 32'h33);
    preloadWord(32'h8002_000C, 32'h44);
    applyStimulus(0, 32'h8002_0000, 1'b1, 2'b01);
    serviceOne();

    $display("[TB] contention, two rounds");
    doReset();
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 32'h8002_0004, 1'b1, 2'b00);
      applyStimulus(1, 32'h8002_0008, 1'b1, 2'b00);
      serviceOne();
      serviceOne();
    end

    $display("[TB] port 1 write 8 words, port 0 reads back");
    for (int k = 0; k < 8; k++) cfgData[1][k] = 32'hA0 + 32'(k);
    applyStimulus(1, 32'h8002_0100, 1'b0, 2'b10);
    serviceOne();
    applyStimulus(0, 32'h8002_0100, 1'b1, 2'b10);
    serviceOne();
    for (int k = 0; k < 8; k++)
      checkOutput("refReadBack", refRead(32'h8002_0100 + 32'(k * 4)), 32'hA0 + 32'(k));

    $display("[TB] busy stall inside a 16-word read");
    for (int k = 0; k < 16; k++) preloadWord(32'h8002_0200 + 32'(k * 4), $urandom);
    busyMode = 1; stallAt = 6; stallLen = 3;
    applyStimulus(0, 32'h8002_0200, 1'b1, 2'b11);
    serviceOne();
    busyMode = 0;

    $display("[TB] address wrap");
    preloadWord(32'hFFFF_FFF8, 32'hCAFE_0001);
    preloadWord(32'hFFFF_FFFC, 32'hCAFE_0002);
    preloadWord(32'h0000_0000, 32'hCAFE_0003);
    preloadWord(32'h0000_0004, 32'hCAFE_0004);
    applyStimulus(0, 32'hFFFF_FFF8, 1'b1, 2'b01);
    serviceOne();

    $display("[TB] reset during a 16-word write");
    for (int k = 0; k < 16; k++) cfgData[1][k] = $urandom;
    abortAt = 5;
    applyStimulus(1, 32'h8002_0400, 1'b0, 2'b11);
    serviceOne();
    abortAt = -1;
    checkOutput("abortReached", 32'(aborted), 32'h1);
    reset = 1'b1;
    #1;
    checkAllZero("resetMid");
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1;
      checkAllZero("resetHold");
    end
    reset = 1'b0;
    modelLast = 1;
    expWait = 1;
    applyStimulus(0, 32'h8002_0400, 1'b1, 2'b11);
    applyStimulus(1, 32'h8002_0000, 1'b1, 2'b00);
    serviceOne();
    serviceOne();

    $display("[TB] randomized traffic");
    for (int it = 0; it < 24; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4);
          else a = 32'h8003_0000 + 32'($urandom_range(0, 40) * 4);
          a = a | 32'($urandom_range(0, 3));
          for (int k = 0; k < 16; k++) cfgData[p][k] = $urandom;
          applyStimulus(p, a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
      end
      busyMode = ($urandom_range(0, 1) == 0) ? 2 : 0;
      cnt = int'(mask[0]) + int'(mask[1]);
      for (int s = 0; s < cnt; s++) serviceOne();
    end
    busyMode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
